// File: rtl/store_pkg.sv
// Shared encodings and width helpers for the store alignment unit.
package store_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } state_e;

    function automatic int offw_f(input int xlen);
        return $clog2(xlen / 8);
    endfunction

    // A size larger than the memory word collapses to a full-word store.
    function automatic logic [1:0] eff_size_f(input logic [1:0] sz, input int offw);
        return (int'(sz) > offw) ? 2'(offw) : sz;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane aligner: masks store data to its size and shifts it into
// byte lanes; beat_sel picks the spill-over half of a word-crossing store.
module store_lane_align #(
    parameter int XLEN = 32,
    parameter int NB   = XLEN / 8,
    parameter int OFFW = $clog2(NB)
) (
    input  logic [XLEN-1:0] data_in,
    input  logic [OFFW-1:0] off,
    input  logic [1:0]      eff_size,
    input  logic            beat_sel,
    output logic [XLEN-1:0] data_out,
    output logic [NB-1:0]   mask_out
);

    logic [NB-1:0]     lane_en;
    logic [XLEN-1:0]   data_masked;
    logic [2*XLEN-1:0] data_wide;
    logic [2*NB-1:0]   mask_wide;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_en[gi]            = (gi < (1 << eff_size));
            assign data_masked[8*gi +: 8] = lane_en[gi] ? data_in[8*gi +: 8] : 8'h00;
        end
    endgenerate

    // Shifting into a double-width word puts beat 0 in the low half and the
    // bytes that spill past the word boundary in the high half.
    assign data_wide = {{XLEN{1'b0}}, data_masked} << {off, 3'b000};
    assign mask_wide = {{NB{1'b0}}, lane_en} << off;

    assign data_out = beat_sel ? data_wide[2*XLEN-1:XLEN] : data_wide[XLEN-1:0];
    assign mask_out = beat_sel ? mask_wide[2*NB-1:NB]     : mask_wide[NB-1:0];

endmodule

// File: rtl/store_align_unit.sv
// Registered store aligner with word-crossing split into two memory beats.
// Define STORE_MISALIGN_EXC_EN to trap crossing stores instead of splitting.
module store_align_unit
    import store_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_data,
    input  logic [1:0]        req_size,
    output logic              dm_valid,
    input  logic              dm_ready,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [XLEN-1:0]   dm_data,
    output logic [XLEN/8-1:0] dm_write,
    output logic              busy,
    output logic              misaligned_exc
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = offw_f(XLEN);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [XLEN-1:0]   dm_data_q, dm_data_d;
    logic [NB-1:0]     dm_write_q, dm_write_d;

    logic [1:0]      req_esz;
    logic [OFFW-1:0] req_off;
    logic            req_split;
    logic            final_beat;
    logic            accept;

    logic [XLEN-1:0] al_data_in, al_data_out;
    logic [OFFW-1:0] al_off;
    logic [1:0]      al_esz;
    logic            al_beat;
    logic [NB-1:0]   al_mask;

    assign req_esz   = eff_size_f(req_size, OFFW);
    assign req_off   = req_addr[OFFW-1:0];
    assign req_split = (int'(req_off) + (1 << req_esz)) > NB;

`ifdef STORE_MISALIGN_EXC_EN
    logic exc_q, exc_d;

    assign final_beat     = (state_q == ST_BEAT0);
    assign al_beat        = 1'b0;
    assign al_data_in     = req_data;
    assign al_off         = req_off;
    assign al_esz         = req_esz;
    assign misaligned_exc = exc_q;
`else
    logic [XLEN-1:0] st_data_q, st_data_d;
    logic [OFFW-1:0] st_off_q, st_off_d;
    logic [1:0]      st_esz_q, st_esz_d;
    logic            st_split_q, st_split_d;

    assign final_beat = (state_q == ST_BEAT1) || ((state_q == ST_BEAT0) && !st_split_q);
    // The aligner serves the captured request only while beat 1 is being formed;
    // req_ready is low then, so it never competes with a new request.
    assign al_beat        = (state_q == ST_BEAT0) && st_split_q;
    assign al_data_in     = al_beat ? st_data_q : req_data;
    assign al_off         = al_beat ? st_off_q  : req_off;
    assign al_esz         = al_beat ? st_esz_q  : req_esz;
    assign misaligned_exc = 1'b0;
`endif

    assign req_ready = (state_q == ST_IDLE) || (final_beat && dm_ready);
    assign accept    = req_valid && req_ready;

    store_lane_align #(.XLEN(XLEN), .NB(NB), .OFFW(OFFW)) u_align (
        .data_in  (al_data_in),
        .off      (al_off),
        .eff_size (al_esz),
        .beat_sel (al_beat),
        .data_out (al_data_out),
        .mask_out (al_mask)
    );

    always_comb begin
        state_d    = state_q;
        dm_addr_d  = dm_addr_q;
        dm_data_d  = dm_data_q;
        dm_write_d = dm_write_q;
`ifdef STORE_MISALIGN_EXC_EN
        exc_d = 1'b0;
        if (accept) begin
            if (req_split) begin
                exc_d      = 1'b1;
                state_d    = ST_IDLE;
                dm_write_d = '0;
            end else begin
                state_d    = ST_BEAT0;
                dm_addr_d  = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
                dm_data_d  = al_data_out;
                dm_write_d = al_mask;
            end
        end else if (state_q != ST_IDLE && dm_ready) begin
            state_d    = ST_IDLE;
            dm_write_d = '0;
        end
`else
        st_data_d  = st_data_q;
        st_off_d   = st_off_q;
        st_esz_d   = st_esz_q;
        st_split_d = st_split_q;
        if (accept) begin
            state_d    = ST_BEAT0;
            dm_addr_d  = {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            dm_data_d  = al_data_out;
            dm_write_d = al_mask;
            st_data_d  = req_data;
            st_off_d   = req_off;
            st_esz_d   = req_esz;
            st_split_d = req_split;
        end else if (state_q != ST_IDLE && dm_ready) begin
            if (al_beat) begin
                state_d    = ST_BEAT1;
                dm_addr_d  = dm_addr_q + ADDR_W'(NB);
                dm_data_d  = al_data_out;
                dm_write_d = al_mask;
            end else begin
                state_d    = ST_IDLE;
                dm_write_d = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            dm_addr_q  <= '0;
            dm_data_q  <= '0;
            dm_write_q <= '0;
`ifdef STORE_MISALIGN_EXC_EN
            exc_q      <= 1'b0;
`else
            st_data_q  <= '0;
            st_off_q   <= '0;
            st_esz_q   <= '0;
            st_split_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            dm_addr_q  <= dm_addr_d;
            dm_data_q  <= dm_data_d;
            dm_write_q <= dm_write_d;
`ifdef STORE_MISALIGN_EXC_EN
            exc_q      <= exc_d;
`else
            st_data_q  <= st_data_d;
            st_off_q   <= st_off_d;
            st_esz_q   <= st_esz_d;
            st_split_q <= st_split_d;
`endif
        end
    end

    assign dm_valid = (state_q != ST_IDLE);
    assign busy     = (state_q != ST_IDLE);
    assign dm_addr  = dm_addr_q;
    assign dm_data  = dm_data_q;
    assign dm_write = dm_write_q;

endmodule

// File: tb/tb_store_align_unit.sv
// Self-checking bench for store_align_unit (XLEN=32): directed literal cases
// followed by randomized stores against a beat-list reference model.
module tb_store_align_unit;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic [31:0] req_data = '0;
    logic [1:0]  req_size = '0;
    logic        dm_valid;
    logic        dm_ready = 1'b0;
    logic [31:0] dm_addr;
    logic [31:0] dm_data;
    logic [3:0]  dm_write;
    logic        busy;
    logic        misaligned_exc;

    always #5 clk = ~clk;

    store_align_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk            (clk),
        .nrst           (nrst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_size       (req_size),
        .dm_valid       (dm_valid),
        .dm_ready       (dm_ready),
        .dm_addr        (dm_addr),
        .dm_data        (dm_data),
        .dm_write       (dm_write),
        .busy           (busy),
        .misaligned_exc (misaligned_exc)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } beat_t;

    beat_t       q[$];
    int          checks = 0;
    int          errors = 0;
    bit          rand_ready = 0;
    bit          exc_next = 0;
    bit          split_m;
    logic [31:0] rnd_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: beats follow directly from size, offset and the word size.
    function automatic bit model_push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int    n, off, m;
        logic [63:0] md;
        beat_t b0, b1;
        bit    split;
        n     = 1 << ((s > 2'd2) ? 2 : int'(s));
        off   = int'(a[1:0]);
        md    = {32'h0, d} & ((64'd1 << (8 * n)) - 64'd1);
        m     = (1 << n) - 1;
        split = (off + n) > 4;
        b0.addr = {a[31:2], 2'b00};
        b0.data = 32'(md << (8 * off));
        b0.mask = 4'(m << off);
        b1.addr = b0.addr + 32'd4;
        b1.data = 32'(md >> (8 * (4 - off)));
        b1.mask = 4'(m >> (4 - off));
`ifdef STORE_MISALIGN_EXC_EN
        if (!split) q.push_back(b0);
`else
        q.push_back(b0);
        if (split) q.push_back(b1);
`endif
        return split;
    endfunction

    always @(negedge clk) begin
        if (!nrst) begin
            q.delete();
            exc_next = 0;
            chk("rst_dm_valid", dm_valid, 0);
            chk("rst_dm_write", dm_write, 0);
        end else begin
            chk("misaligned_exc", misaligned_exc, exc_next);
            exc_next = 0;
            chk("dm_valid", dm_valid, q.size() != 0);
            chk("busy", busy, q.size() != 0);
            chk("req_ready", req_ready, (q.size() == 0) || (q.size() == 1 && dm_ready));
            if (q.size() != 0) begin
                chk("dm_addr", dm_addr, q[0].addr);
                chk("dm_data", dm_data, q[0].data);
                chk("dm_write", dm_write, q[0].mask);
                if (dm_ready) void'(q.pop_front());
            end else begin
                chk("dm_write_idle", dm_write, 0);
            end
            if (req_valid && req_ready) begin
                $display("req addr=%08h data=%08h size=%0d", req_addr, req_data, req_size);
                split_m = model_push(req_addr, req_data, req_size);
`ifdef STORE_MISALIGN_EXC_EN
                exc_next = split_m;
`endif
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            dm_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        bit done = 0;
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = s;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (req_ready) done = 1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got req_ready=0 expected 1 within 100 cycles");
        end
    endtask

    task automatic expect_beat(input string name, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m);
        chk({name, "_valid"}, dm_valid, 1);
        chk({name, "_addr"}, dm_addr, a);
        chk({name, "_data"}, dm_data, d);
        chk({name, "_mask"}, dm_write, m);
    endtask

    initial begin
        #1;
        chk("reset_dm_valid", dm_valid, 0);
        chk("reset_dm_addr", dm_addr, 0);
        chk("reset_dm_data", dm_data, 0);
        chk("reset_dm_write", dm_write, 0);
        chk("reset_busy", busy, 0);
        chk("reset_exc", misaligned_exc, 0);
        @(posedge clk);
        #1;
        nrst     = 1'b1;
        dm_ready = 1'b1;

        send(32'h0000_3002, 32'hFFFF_FF5A, 2'd0);
        @(negedge clk);
        expect_beat("t1_sb", 32'h0000_3000, 32'h005A_0000, 4'b0100);
        @(posedge clk); #1;

        send(32'h0000_2001, 32'h0000_1234, 2'd1);
        @(negedge clk);
        expect_beat("t2_sh", 32'h0000_2000, 32'h0012_3400, 4'b0110);
        @(posedge clk); #1;

`ifndef STORE_MISALIGN_EXC_EN
        send(32'h0000_1003, 32'hAABB_CCDD, 2'd2);
        @(negedge clk);
        expect_beat("t3_b0", 32'h0000_1000, 32'hDD00_0000, 4'b1000);
        chk("t3_ready_b0", req_ready, 0);
        @(negedge clk);
        expect_beat("t3_b1", 32'h0000_1004, 32'h00AA_BBCC, 4'b0111);
        @(posedge clk); #1;
`endif

        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                req_valid = 1'b1;
                req_addr  = 32'(4 * i);
                req_data  = 32'h1111_0000 + 32'(i);
                req_size  = 2'd2;
            end else begin
                req_valid = 1'b0;
                dm_ready  = 1'b0;
            end
            if (i > 0) begin
                @(negedge clk);
                chk("t4_b2b_valid", dm_valid, 1);
                chk("t4_b2b_addr", dm_addr, 32'(4 * (i - 1)));
                chk("t4_b2b_ready", req_ready, i < 3);
            end
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            expect_beat("t4_hold", 32'h0000_0008, 32'h1111_0002, 4'b1111);
            chk("t4_hold_ready", req_ready, 0);
            @(posedge clk); #1;
        end
        dm_ready = 1'b1;
        @(posedge clk); #1;

`ifndef STORE_MISALIGN_EXC_EN
        send(32'hFFFF_FFFE, 32'h1122_3344, 2'd2);
        @(negedge clk);
        expect_beat("t5_b0", 32'hFFFF_FFFC, 32'h3344_0000, 4'b1100);
        @(negedge clk);
        expect_beat("t5_b1", 32'h0000_0000, 32'h0000_1122, 4'b0011);
        @(posedge clk); #1;

        dm_ready = 1'b0;
        send(32'hFFFF_FFFE, 32'h5566_7788, 2'd2);
        @(negedge clk);
        expect_beat("t5r_b0", 32'hFFFF_FFFC, 32'h7788_0000, 4'b1100);
        @(posedge clk); #2;
        nrst = 1'b0;
        #1;
        chk("t5r_dm_valid", dm_valid, 0);
        chk("t5r_dm_addr", dm_addr, 0);
        chk("t5r_dm_data", dm_data, 0);
        chk("t5r_dm_write", dm_write, 0);
        chk("t5r_busy", busy, 0);
        chk("t5r_exc", misaligned_exc, 0);
        @(posedge clk); #1;
        dm_ready = 1'b1;
        nrst     = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("t5r_no_beat1", dm_valid, 0);
        end
        @(posedge clk); #1;
`else
        send(32'h0000_0003, 32'h0000_BEEF, 2'd1);
        @(negedge clk);
        chk("t6_no_beat", dm_valid, 0);
        chk("t6_exc", misaligned_exc, 1);
        chk("t6_ready", req_ready, 1);
        @(posedge clk); #1;
        send(32'h0000_0010, 32'hCAFE_F00D, 2'd2);
        @(negedge clk);
        expect_beat("t6_sw", 32'h0000_0010, 32'hCAFE_F00D, 4'b1111);
        chk("t6_exc_once", misaligned_exc, 0);
        @(posedge clk); #1;
`endif

        rand_ready = 1;
        for (int k = 0; k < 200; k++) begin
            rnd_addr = $urandom;
            if ($urandom_range(0, 3) == 0) rnd_addr = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            send(rnd_addr, $urandom, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 0;
        @(posedge clk); #2;
        dm_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!dm_valid) break;
        end
        chk("drain_idle", dm_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
